serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to begin an addition; sampled on clk.
REQ-005 a  input  WIDTH  operand A, captured on start accept.
REQ-006 b  input  WIDTH  operand B, captured on start accept.
REQ-007 cin  input  1  carry-in, captured on start accept.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 cout  output  1  registered final carry-out.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using a single one-bit full adder for one bit per clock.
REQ-013 FSM states SHALL be IDLE, RUN and DONE: IDLE->RUN on start=1; RUN->DONE after the WIDTH-th bit; DONE->IDLE unconditionally after one cycle.
REQ-014 On the start-accept edge (IDLE and start=1), the block SHALL capture a, b and cin into internal registers, clear the bit counter to 0 and load the carry register with cin.
REQ-015 In RUN, each edge SHALL feed bit[count] of captured A/B plus the carry register to the full adder, store the sum bit, load carry with the adder carry-out and increment count.
REQ-016 The counter SHALL be $clog2(WIDTH)+1 bits wide; RUN exits when count reaches WIDTH-1 on the processing edge, with no wrap-around.
REQ-017 busy SHALL be high exactly WIDTH cycles, starting the cycle after the accept edge.
REQ-018 done SHALL be high for exactly one cycle, beginning WIDTH edges after the accept edge.
REQ-019 sum and cout SHALL update only on the RUN->DONE edge and hold their value until the next RUN->DONE edge.
REQ-020 start SHALL be ignored in RUN and DONE, and changes to a/b/cin after accept SHALL NOT affect the result.
REQ-021 start held high continuously SHALL be accepted again on the first IDLE cycle after DONE, giving back-to-back operations of WIDTH+2 cycles each.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, clear the counter and carry, and abort any operation in progress with no done pulse.
REQ-023 start SHALL NOT be accepted on an edge where rst_n=0.

Configuration
REQ-024 Macro SERIAL_ADDER_SUB_EN SHALL add input port sub (1 bit, captured on accept); with sub=1 the block SHALL compute a + ~b + 1 (cin ignored), and cout=1 SHALL mean no borrow.
REQ-025 Without SERIAL_ADDER_SUB_EN, port sub SHALL NOT exist and behaviour SHALL be addition only, as specified above.

Structure
REQ-026 Package serial_adder_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-027 The per-bit arithmetic SHALL be an instance of the team's existing full_adder sub-module (ports a, b, c, s, cout), and the controller SHALL contain no other adder logic.

Verification
REQ-028 WIDTH=8, a=8'h0F, b=8'h01, cin=0, one-cycle start -> busy for 8 cycles; done 8 edges after accept; sum=8'h10, cout=0.
REQ-029 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0, with the prior result held until the new done.
REQ-030 start pulsed mid-RUN and a/b changed mid-RUN -> no restart; result matches the operands captured at accept; exactly one done pulse.
REQ-031 rst_n=0 for one edge at bit 4 of an operation -> busy=0, sum=0, cout=0 next cycle, no done pulse; a new start then completes normally.
REQ-032 start held high for 30 cycles -> done pulses every 10 cycles, and each result is correct for the operands present at its accept edge.
REQ-033 With SERIAL_ADDER_SUB_EN: a=8'd5, b=8'd7, sub=1 -> sum=8'hFE, cout=0; a=8'd7, b=8'd5, sub=1 -> sum=8'h02, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder used as the serial adder's per-bit datapath.
// Ports:
//   a, b  - operand bits
//   c     - carry-in
//   s     - sum bit
//   cout  - carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: computes {cout,sum} = a + b + cin one bit per
// clock, LSB first, through a single full_adder instance.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds input 'sub'; with sub=1 the
// block computes a + ~b + 1 (cin ignored), cout=1 meaning no borrow.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - begin an addition (accepted only in IDLE)
//   a, b   - WIDTH-bit operands, captured on accept
//   cin    - carry-in, captured on accept
//   sub    - subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when sum/cout are updated
//   sum    - registered result
//   cout   - registered final carry-out
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [IDX_W-1:0]   bit_idx;
  logic               fa_a, fa_b, fa_s, fa_cout;

  // Counter never exceeds WIDTH-1 while indexing, so the low bits suffice.
  assign bit_idx = cnt_q[IDX_W-1:0];
  assign fa_a    = a_q[bit_idx];
  assign fa_b    = b_q[bit_idx];

  full_adder u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .c    (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtraction as a + ~b + 1: invert B once at capture.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        res_d[bit_idx] = fa_s;
        carry_d        = fa_cout;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last bit: publish the full result in one step.
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = res_d;
          cout_d  = fa_cout;
        end else begin
          busy_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder_ctrl
